hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard detection and operand forwarding control for a
//                five-stage MIPS-style pipeline, with an optional tracker
//                for a multi-cycle multiply/divide unit.
//
//  Purpose
//    - Picks the EX-stage operand sources (regfile / WB / MEM forwarding).
//    - Picks the ID-stage branch-compare operand source (regfile / MEM).
//    - Raises the pipeline stalls for load-use, branch-compare and HI/LO
//      hazards, and the IF/ID flush for taken branches.
//    - Tracks mult/div occupancy and raises MdBusy (MDU build only).
//
//  Configuration
//    HAZARD_CTRL_MDU_EN : when defined, the mult/div occupancy FSM is built.
//                         When undefined, MdBusy is tied low and the
//                         MdStartE / MdOpE / HiLoUseD inputs have no effect.
//
//  Parameters
//    MULT_CYCLES : multiply latency in cycles (2..31)
//    DIV_CYCLES  : divide latency in cycles   (2..63)
//
//  Ports
//    clk, rst_n                  : clock, synchronous active-low reset
//    RsD, RtD                    : ID-stage source registers
//    RsE, RtE, WriteRegE         : EX-stage sources and destination
//    WriteRegM, WriteRegW        : MEM / WB destinations
//    RegWriteE/M/W               : stage register-write flags
//    MemtoRegE/M                 : stage load flags
//    BranchD, PCSrcD             : ID branch compare, taken redirect
//    MdStartE, MdOpE, HiLoUseD   : mult/div issue, op (0=mult 1=div),
//                                  ID instruction touches HI/LO
//    StallF, StallD              : IF / ID hold
//    FlushD, FlushE              : IF/ID clear, ID/EX clear
//    ForwardAE, ForwardBE        : EX operand select (00 RF, 01 WB, 10 MEM)
//    ForwardAD, ForwardBD        : ID compare operand from MEM
//    MdBusy                      : multi-cycle unit occupied
//
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  // ID stage
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  // EX stage
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  // MEM / WB destinations
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  // Stage write / load flags
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  // Branch control
  input  logic       BranchD,
  input  logic       PCSrcD,
  // Mult/div control
  input  logic       MdStartE,
  input  logic       MdOpE,
  input  logic       HiLoUseD,
  // Pipeline control
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MdBusy
);

  localparam logic [1:0] C_FWD_RF  = 2'b00;
  localparam logic [1:0] C_FWD_WB  = 2'b01;
  localparam logic [1:0] C_FWD_MEM = 2'b10;

  // --------------------------------------------------------------------------
  // EX-stage forwarding. The MEM result is younger than the WB result, so it
  // wins when both stages target the same register. $0 is never forwarded.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] fwd_ex_sel(
    input logic [4:0] src,
    input logic       regwr_m,
    input logic [4:0] dst_m,
    input logic       regwr_w,
    input logic [4:0] dst_w
  );
    logic [1:0] sel;
    sel = C_FWD_RF;
    if ((src != 5'd0) && regwr_m && (src == dst_m)) begin
      sel = C_FWD_MEM;
    end else if ((src != 5'd0) && regwr_w && (src == dst_w)) begin
      sel = C_FWD_WB;
    end
    return sel;
  endfunction

  logic [1:0] w_fwd_a_e;
  logic [1:0] w_fwd_b_e;
  logic       w_fwd_a_d;
  logic       w_fwd_b_d;

  always_comb begin
    w_fwd_a_e = fwd_ex_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    w_fwd_b_e = fwd_ex_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  end

  // ID-stage compare operands can only be bypassed from MEM; a WB result is
  // already visible through the write-first register file.
  assign w_fwd_a_d = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
  assign w_fwd_b_d = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);

  // --------------------------------------------------------------------------
  // Stall detection
  // --------------------------------------------------------------------------
  // Destination of EX / MEM matches either ID source (excluding $0).
  logic w_hit_e;
  logic w_hit_m;
  logic w_lwstall;
  logic w_brstall;
  logic w_mdstall;
  logic w_stall;
  logic w_md_busy;

  assign w_hit_e = (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign w_hit_m = (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD));

  // Load in EX: the data does not exist until the end of MEM.
  assign w_lwstall = MemtoRegE && w_hit_e;

  // Branch compares in ID need the operand one stage earlier than an ALU
  // user, so an ALU result still in EX or a load still in MEM must wait.
  assign w_brstall = BranchD && ((RegWriteE && w_hit_e) || (MemtoRegM && w_hit_m));

  // Only an operation already in flight blocks HI/LO users; the issue cycle
  // itself does not, since w_md_busy is purely registered state.
  assign w_mdstall = w_md_busy && HiLoUseD;

  assign w_stall = w_lwstall | w_brstall | w_mdstall;

  // --------------------------------------------------------------------------
  // Mult/div occupancy tracker
  // --------------------------------------------------------------------------
`ifdef HAZARD_CTRL_MDU_EN
  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // The counter is loaded with latency-1 and the FSM leaves BUSY on the edge
  // that sees it at zero, so BUSY lasts exactly the latency in cycles.
  localparam logic [5:0] C_MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] C_DIV_LOAD  = 6'(DIV_CYCLES - 1);

  md_state_e  state_q;
  md_state_e  state_d;
  logic [5:0] cnt_q;
  logic [5:0] cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (MdStartE) begin
          state_d = MD_BUSY;
          cnt_d   = MdOpE ? C_DIV_LOAD : C_MULT_LOAD;
        end
      end
      MD_BUSY: begin
        // A new MdStartE here is deliberately not looked at: the unit has
        // a single operation slot and the counter must run to completion.
        if (cnt_q == 6'd0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  assign w_md_busy = (state_q == MD_BUSY);
`else
  assign w_md_busy = 1'b0;

  // Inputs and parameters that only feed the tracker are intentionally
  // left without a load in this build.
  logic w_unused_md;
  assign w_unused_md = &{1'b0, clk, MdStartE, MdOpE,
                         (MULT_CYCLES != 0), (DIV_CYCLES != 0)};
`endif

  // --------------------------------------------------------------------------
  // Outputs. Every output, combinational or not, is forced low while reset
  // is asserted so the pipeline sees no stall/flush/forward during reset.
  // --------------------------------------------------------------------------
  assign StallF    = rst_n & w_stall;
  assign StallD    = rst_n & w_stall;
  assign FlushE    = rst_n & w_stall;
  // A stalled ID stage holds the branch, so its redirect is not yet final.
  assign FlushD    = rst_n & PCSrcD & ~w_stall;
  assign ForwardAE = rst_n ? w_fwd_a_e : C_FWD_RF;
  assign ForwardBE = rst_n ? w_fwd_b_e : C_FWD_RF;
  assign ForwardAD = rst_n & w_fwd_a_d;
  assign ForwardBD = rst_n & w_fwd_b_d;
  assign MdBusy    = rst_n & w_md_busy;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Each cycle's stimulus
//                pushes its expected output vector into a scoreboard queue;
//                the vector is popped and compared on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int C_MULT = 4;
  localparam int C_DIV  = 32;
`ifdef HAZARD_CTRL_MDU_EN
  localparam bit C_MDU_ON = 1'b1;
`else
  localparam bit C_MDU_ON = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic regw_e, regw_m, regw_w, m2r_e, m2r_m;
    logic branch, pcsrc, mdstart, mdop, hilo, rst_n;
  } stim_t;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur = '0;

  logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;

  hazard_ctrl #(
    .MULT_CYCLES (C_MULT),
    .DIV_CYCLES  (C_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (cur.rst_n),
    .RsD       (cur.rs_d),
    .RtD       (cur.rt_d),
    .RsE       (cur.rs_e),
    .RtE       (cur.rt_e),
    .WriteRegE (cur.wr_e),
    .WriteRegM (cur.wr_m),
    .WriteRegW (cur.wr_w),
    .RegWriteE (cur.regw_e),
    .RegWriteM (cur.regw_m),
    .RegWriteW (cur.regw_w),
    .MemtoRegE (cur.m2r_e),
    .MemtoRegM (cur.m2r_m),
    .BranchD   (cur.branch),
    .PCSrcD    (cur.pcsrc),
    .MdStartE  (cur.mdstart),
    .MdOpE     (cur.mdop),
    .HiLoUseD  (cur.hilo),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .MdBusy    (MdBusy)
  );

  sb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  m_left   = 0;   // model: busy cycles still to come
  int  busy_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected output vector:
  // {StallF, StallD, FlushD, FlushE, FwdAE[1:0], FwdBE[1:0], FwdAD, FwdBD, MdBusy}
  function automatic logic [10:0] exp_of(input stim_t s, input bit busy);
    logic [1:0] fa, fb;
    logic       fad, fbd, lw, br, md, st;
    if (!s.rst_n) return 11'd0;
    fa  = (s.rs_e != 0 && s.regw_m && s.rs_e == s.wr_m) ? 2'b10 :
          (s.rs_e != 0 && s.regw_w && s.rs_e == s.wr_w) ? 2'b01 : 2'b00;
    fb  = (s.rt_e != 0 && s.regw_m && s.rt_e == s.wr_m) ? 2'b10 :
          (s.rt_e != 0 && s.regw_w && s.rt_e == s.wr_w) ? 2'b01 : 2'b00;
    fad = (s.rs_d != 0) && s.regw_m && (s.rs_d == s.wr_m);
    fbd = (s.rt_d != 0) && s.regw_m && (s.rt_d == s.wr_m);
    lw  = s.m2r_e && (s.wr_e != 0) && (s.wr_e == s.rs_d || s.wr_e == s.rt_d);
    br  = s.branch &&
          ((s.regw_e && s.wr_e != 0 && (s.wr_e == s.rs_d || s.wr_e == s.rt_d)) ||
           (s.m2r_m  && s.wr_m != 0 && (s.wr_m == s.rs_d || s.wr_m == s.rt_d)));
    md  = busy && s.hilo;
    st  = lw | br | md;
    return {st, st, s.pcsrc & ~st, st, fa, fb, fad, fbd, busy};
  endfunction

  task automatic model_edge(input stim_t s);
    if (!s.rst_n)          m_left = 0;
    else if (m_left > 0)   m_left--;
    else if (C_MDU_ON && s.mdstart) m_left = s.mdop ? C_DIV : C_MULT;
  endtask

  // One cycle: drive, push expectation, pop/compare at negedge, advance model.
  task automatic step(input stim_t s, input string tag, input bit use_const,
                      input logic [10:0] cexp);
    sb_t e;
    cur   = s;
    e.tag = tag;
    e.exp = use_const ? cexp : exp_of(s, m_left > 0);
    sb.push_back(e);
    @(negedge clk);
    if (MdBusy) busy_cnt++;
    e = sb.pop_front();
    check_eq(e.tag, {21'd0, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
                     ForwardAD, ForwardBD, MdBusy}, {21'd0, e.exp});
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  function automatic stim_t run_stim();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    stim_t s;
    @(posedge clk);
    #1;

    // Reset with hazardous inputs present: every output must read 0.
    s = '0;
    s.rs_e = 5; s.regw_m = 1; s.wr_m = 5; s.m2r_e = 1; s.wr_e = 8; s.rt_d = 8;
    s.pcsrc = 1; s.rs_d = 5; s.hilo = 1;
    step(s, "reset_a", 1, 11'd0);
    step(s, "reset_b", 1, 11'd0);

    s = run_stim(); s.rs_e = 5; s.regw_m = 1; s.wr_m = 5; s.regw_w = 1; s.wr_w = 5;
    step(s, "fwd_mem_prio", 1, 11'b0000_10_00_0_0_0);
    s = run_stim();
    step(s, "fwd_zero", 1, 11'd0);
    s = run_stim(); s.rt_e = 7; s.regw_w = 1; s.wr_w = 7; s.regw_m = 1; s.wr_m = 6;
    step(s, "fwd_wb", 1, 11'b0000_00_01_0_0_0);
    s = run_stim(); s.regw_m = 1; s.regw_w = 1;
    step(s, "fwd_r0", 1, 11'd0);
    s = run_stim(); s.m2r_e = 1; s.wr_e = 8; s.rt_d = 8;
    step(s, "lwstall", 1, 11'b1101_00_00_0_0_0);
    s.m2r_e = 0;
    step(s, "lw_clear", 1, 11'd0);
    s = run_stim(); s.m2r_e = 1; s.wr_e = 0;
    step(s, "lw_r0", 1, 11'd0);
    s = run_stim(); s.branch = 1; s.regw_e = 1; s.wr_e = 3; s.rs_d = 3; s.pcsrc = 1;
    step(s, "br_stall", 1, 11'b1101_00_00_0_0_0);
    s.regw_e = 0;
    step(s, "br_clear", 1, 11'b0010_00_00_0_0_0);
    s = run_stim(); s.m2r_e = 1; s.wr_e = 8; s.rs_d = 8; s.pcsrc = 1;
    step(s, "lw_pcsrc", 1, 11'b1101_00_00_0_0_0);
    s = run_stim(); s.branch = 1; s.m2r_m = 1; s.regw_m = 1; s.wr_m = 4; s.rt_d = 4;
    step(s, "br_mem_load", 1, 11'b1101_00_00_0_1_0);
    s = run_stim(); s.rs_d = 9; s.regw_m = 1; s.wr_m = 9;
    step(s, "fwd_id", 1, 11'b0000_00_00_1_0_0);
    s = run_stim(); s.regw_e = 1; s.wr_e = 3; s.rs_d = 3;
    step(s, "no_branch_e", 1, 11'd0);

    // Multiply with HI/LO user waiting, plus an ignored second start.
    busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      s = run_stim();
      s.hilo    = 1'b1;
      s.mdstart = (c == 0) || (c == 2);
      s.mdop    = (c == 2);
      step(s, "md_mult", 0, 11'd0);
    end
    check_eq("md_mult_busy_cycles", busy_cnt, C_MDU_ON ? 4 : 0);

    // Divide aborted by reset on cycle 10.
    busy_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      s = run_stim();
      s.mdstart = (c == 0);
      s.mdop    = 1'b1;
      s.hilo    = c[0];
      s.rst_n   = (c != 10);
      step(s, "md_div_rst", 0, 11'd0);
    end
    check_eq("md_div_busy_cycles", busy_cnt, C_MDU_ON ? 9 : 0);

    // Random traffic on a small register range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      s = run_stim();
      s.rs_d = 5'($urandom_range(0, 3)); s.rt_d = 5'($urandom_range(0, 3));
      s.rs_e = 5'($urandom_range(0, 3)); s.rt_e = 5'($urandom_range(0, 3));
      s.wr_e = 5'($urandom_range(0, 3)); s.wr_m = 5'($urandom_range(0, 3));
      s.wr_w = 5'($urandom_range(0, 3));
      s.regw_e = 1'($urandom); s.regw_m = 1'($urandom); s.regw_w = 1'($urandom);
      s.m2r_e  = 1'($urandom); s.m2r_m  = 1'($urandom);
      s.branch = 1'($urandom); s.pcsrc  = 1'($urandom);
      s.mdstart = ($urandom_range(0, 7) == 0);
      s.mdop    = 1'($urandom);
      s.hilo    = 1'($urandom);
      s.rst_n   = ($urandom_range(0, 49) != 0);
      step(s, "rand", 0, 11'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
